cascade_down_timer: RTL and testbench
=====================================

Name: cascade_down_timer

Overview:
- Loadable, multi-stage cascaded down-counter. It is the counting-down counterpart of the team's up-counting enable/tc counter chains.
- Each stage decrements only when every lower stage has hit zero, so the borrow ripples through the chain the same way tc ripples up through the up-count chains.
- Loaded through a valid/ready handshake. Emits a one-cycle done pulse at terminal zero and optionally auto-reloads.
- Sits beside the counter chains as the programmable timeout/interval source for the Project 2 fabric.

Parameters:
- STAGE_WIDTH, 16, width in bits of one cascade stage.
- NUM_STAGES, 4, number of cascaded stages. Total count width W = STAGE_WIDTH*NUM_STAGES.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on clk; 0 = reset.
- load_valid  input  1  load request.
- load_ready  output  1  high only in IDLE.
- load_value  input  W  start value, captured on handshake.
- reload  input  1  sampled in DONE: 1 = reload captured start value and continue.
- enable  input  1  count-enable strobe; one decrement per enabled RUN cycle.
- stop  input  1  abort the run.
- count  output  W  current count, registered.
- stage_borrow  output  NUM_STAGES  combinational borrow out of each stage.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse at terminal count.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, count=0, captured value=0, done=0, busy=0. This applies in any state, including mid-run. No done is generated by reset.
- States: IDLE, RUN, DONE. Encoding is free. busy = (state==RUN); load_ready = (state==IDLE).
- IDLE:
  - load_valid & load_ready: count<=load_value and load_value is captured.
  - If load_value!=0, go to RUN.
  - If load_value==0, go to DONE (done asserted the next cycle).
  - Otherwise hold; count keeps its last value.
- RUN:
  - Stage k is count[k*STAGE_WIDTH +: STAGE_WIDTH].
  - stage_borrow[k] = busy & enable & (stages 0..k all zero).
  - Stage 0 decrements when enable. Stage k>0 decrements when enable & stage_borrow[k-1].
  - A decrementing zero stage wraps to all ones. Example at W=8, STAGE_WIDTH=4: 0x10 -> 0x0F in one cycle.
  - When enable & count==1: count<=0 and state<=DONE.
  - enable==0: count holds, no state change.
  - load_valid in RUN is ignored (load_ready=0) and has no effect.
- stop in RUN:
  - Next state IDLE, count holds its current value, no done.
  - stop has priority over a same-cycle terminal decrement: count stays 1, no done.
  - stop outside RUN is ignored.
- DONE (exactly one cycle):
  - done=1 and count==0.
  - If reload==1 and the captured value !=0: count<=captured value, state<=RUN.
  - If reload==1 and the captured value ==0: count stays 0, state<=DONE, so done repeats every cycle.
  - Otherwise state<=IDLE.
- Timing:
  - done is combinational from state (state==DONE), no extra register stage.
  - Latency from handshake to done: N enabled RUN cycles plus 1 cycle, for load value N.
  - Between consecutive reload periods, done is high for exactly 1 cycle and count reads 0 for exactly 1 cycle.
- stage_borrow[NUM_STAGES-1] is asserted only on a wrap from all-zero, which cannot occur in RUN because the terminal transition exits at count 1. It is therefore 0 in normal operation and is kept for chaining further timers.
- Arithmetic is unsigned modulo 2^STAGE_WIDTH per stage. No saturation.

Test Plan:
(All scenarios use STAGE_WIDTH=4, NUM_STAGES=2, W=8.)
- Basic run with stage borrow:
  - Stimulus: reset low 2 cycles, then high; load 0x12; enable=1 constant.
  - Response: count reads 0x12, 0x11, 0x10, 0x0F, … with stage_borrow[0]=1 on the 0x10 cycle. After 18 enabled cycles count=0x00, done=1 for exactly one cycle, then load_ready=1.
- Enable gating:
  - Stimulus: load 0x05; enable high every other cycle.
  - Response: done occurs 10 cycles after the handshake (5 enabled cycles interleaved with 4 idle ones, plus 1); count holds on enable=0 cycles.
- Auto-reload:
  - Stimulus: load 0x03, reload=1, enable=1.
  - Response: done pulses every 4 cycles (3 counts + 1 DONE), indefinitely. Count sequence is 3, 2, 1, 0, 3, 2, 1, 0, …
- Zero load:
  - Stimulus: load 0x00, reload=0.
  - Response: one cycle after the handshake, done=1 for one cycle, then IDLE. A second load_valid during DONE is not accepted (load_ready=0).
- Stop, with priority over terminal:
  - Stimulus 1: load 0x20; stop asserted at count 0x1A.
  - Response 1: IDLE, count holds 0x1A, no done.
  - Stimulus 2: load 0x01; assert stop together with enable in the first RUN cycle.
  - Response 2: IDLE, count stays 0x01, no done.
- Reset mid-run:
  - Stimulus: load 0xFF; enable; drive reset=0 for one edge at count 0x80.
  - Response: next cycle count=0, busy=0, done=0, load_ready=1. No done pulse is ever produced for the aborted run.

Source files
------------

// File: rtl/cascade_down_timer.sv
// Loadable cascaded down-counter: each stage borrows from the next only when all lower stages are zero.
// Handshake load, one-cycle done pulse at terminal zero, optional auto-reload of the captured start value.
module cascade_down_timer #(
  parameter int STAGE_WIDTH = 16,
  parameter int NUM_STAGES  = 4,
  parameter int W           = STAGE_WIDTH * NUM_STAGES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [W-1:0]          load_value,
  input  logic                  reload,
  input  logic                  enable,
  input  logic                  stop,
  output logic [W-1:0]          count,
  output logic [NUM_STAGES-1:0] stage_borrow,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [STAGE_WIDTH-1:0] STAGE_ONE = STAGE_WIDTH'(1);
  localparam logic [W-1:0]           CNT_ONE   = W'(1);

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   cap_q, cap_d;
  logic [W-1:0]   count_dec;
  logic           chain;

  assign busy       = (state_q == S_RUN);
  assign load_ready = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign count      = count_q;

  // chain carries "enabled and every lower stage is zero" upward through the stages
  always_comb begin
    count_dec    = count_q;
    stage_borrow = '0;
    chain        = busy & enable;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (chain) begin
        count_dec[k*STAGE_WIDTH +: STAGE_WIDTH] = count_q[k*STAGE_WIDTH +: STAGE_WIDTH] - STAGE_ONE;
      end
      chain           = chain & (count_q[k*STAGE_WIDTH +: STAGE_WIDTH] == '0);
      stage_borrow[k] = chain;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          count_d = load_value;
          cap_d   = load_value;
          state_d = (load_value != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        // stop wins over a same-cycle terminal decrement
        if (stop) begin
          state_d = S_IDLE;
        end else if (enable) begin
          count_d = count_dec;
          if (count_q == CNT_ONE) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (reload && (cap_q != '0)) begin
          count_d = cap_q;
          state_d = S_RUN;
        end else if (reload) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cap_q   <= cap_d;
    end
  end

endmodule

// File: tb/tb_cascade_down_timer.sv
// Directed bench for cascade_down_timer at STAGE_WIDTH=4, NUM_STAGES=2.
module tb_cascade_down_timer;

  localparam int SW = 4;
  localparam int NS = 2;
  localparam int W  = SW * NS;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  load_value;
  logic          reload;
  logic          enable;
  logic          stop;
  logic [W-1:0]  count;
  logic [NS-1:0] stage_borrow;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int exp_cnt;

  always #5 clk = ~clk;

  cascade_down_timer #(.STAGE_WIDTH(SW), .NUM_STAGES(NS)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_value(load_value), .reload(reload), .enable(enable), .stop(stop),
    .count(count), .stage_borrow(stage_borrow), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_value = '0;
    reload = 1'b0; enable = 1'b0; stop = 1'b0;

    // reset state
    tick(); tick();
    reset = 1'b1;
    check("rst_count", count, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", load_ready, 1);

    // basic run with stage borrow
    enable = 1'b1;
    do_load(8'h12);
    check("s1_load_count", count, 8'h12);
    check("s1_busy", busy, 1);
    check("s1_ready", load_ready, 0);
    tick(); tick();
    check("s1_count_10", count, 8'h10);
    check("s1_borrow_10", stage_borrow, 2'b01);
    tick();
    check("s1_count_0f", count, 8'h0F);
    check("s1_borrow_0f", stage_borrow, 2'b00);
    for (int i = 0; i < 14; i++) tick();
    check("s1_count_01", count, 8'h01);
    check("s1_done_early", done, 0);
    tick();
    check("s1_count_00", count, 8'h00);
    check("s1_done", done, 1);
    check("s1_done_busy", busy, 0);
    tick();
    check("s1_done_once", done, 0);
    check("s1_ready_after", load_ready, 1);

    // enable gating: enable on alternate RUN cycles
    enable = 1'b0;
    do_load(8'h05);
    exp_cnt = 5;
    for (int i = 0; i < 9; i++) begin
      enable = (i % 2 == 0);
      if (enable) exp_cnt--;
      tick();
      check($sformatf("s2_count_%0d", i), count, exp_cnt);
      check($sformatf("s2_done_%0d", i), done, (i == 8));
    end
    enable = 1'b0;
    tick();
    check("s2_done_off", done, 0);
    check("s2_ready", load_ready, 1);

    // auto-reload
    reload = 1'b1;
    enable = 1'b1;
    do_load(8'h03);
    check("s3_load", count, 3);
    for (int j = 1; j <= 11; j++) begin
      tick();
      check($sformatf("s3_count_%0d", j), count, (j % 4 == 3) ? 0 : 3 - (j % 4));
      check($sformatf("s3_done_%0d", j), done, (j % 4 == 3));
    end
    reload = 1'b0;
    tick();
    check("s3_exit_ready", load_ready, 1);
    check("s3_exit_done", done, 0);

    // zero load; load attempt during DONE must be refused
    enable = 1'b0;
    do_load(8'h00);
    check("s4_done", done, 1);
    check("s4_count", count, 0);
    check("s4_ready_in_done", load_ready, 0);
    load_valid = 1'b1;
    load_value = 8'h44;
    tick();
    load_valid = 1'b0;
    check("s4_no_load", count, 0);
    check("s4_idle", load_ready, 1);
    check("s4_done_once", done, 0);

    // stop mid-run
    enable = 1'b1;
    do_load(8'h20);
    for (int i = 0; i < 6; i++) tick();
    check("s5_count_1a", count, 8'h1A);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s5_stop_count", count, 8'h1A);
    check("s5_stop_idle", load_ready, 1);
    check("s5_stop_busy", busy, 0);
    check("s5_stop_done", done, 0);
    tick();
    check("s5_hold", count, 8'h1A);

    // stop beats terminal decrement
    do_load(8'h01);
    check("s5b_run", busy, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("s5b_count", count, 8'h01);
    check("s5b_done", done, 0);
    check("s5b_idle", load_ready, 1);
    tick();
    check("s5b_done_later", done, 0);

    // reset mid-run
    do_load(8'hFF);
    for (int i = 0; i < 127; i++) tick();
    check("s6_count_80", count, 8'h80);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("s6_count", count, 0);
    check("s6_busy", busy, 0);
    check("s6_done", done, 0);
    check("s6_ready", load_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("s6_no_done_%0d", i), done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
